clk_div_gen: RTL and testbench

CLK_DIV_GEN -- requirements
Module: clk_div_gen

---
 rtl/clk_div_gen.sv | 155 +++++++++++++++
 tb/tb_clk_div_gen.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_gen.sv
// Programmable clock divider: produces a registered divided clock, a per-period tick and a period count.
// Optional build macro CLK_DIV_GEN_LIMIT_EN adds a period limit input and a done pulse.
module clk_div_gen #(
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 4
) (
    input  logic             fastclk,
    input  logic             reset_l,
    input  logic             run_en,
    input  logic             cfg_valid,
    input  logic [DIV_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             clk_out,
    output logic             tick,
    output logic [31:0]      slow_count,
    output logic             busy
`ifdef CLK_DIV_GEN_LIMIT_EN
    ,
    input  logic [31:0]      limit,
    output logic             done
`endif
);

    localparam int               RST_DIV_INT = (DEFAULT_DIV < 2) ? 2 : DEFAULT_DIV;
    localparam logic [DIV_W-1:0] RST_DIV     = DIV_W'(RST_DIV_INT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] r_pend_div;
    logic             r_pend_q;
    logic             r_clk_out;
    logic             r_tick;
    logic [31:0]      r_slow_count;

    logic [DIV_W-1:0] w_cnt_next;
    logic [DIV_W-1:0] w_div_next;
    logic [DIV_W-1:0] w_cfg_clamped;
    logic             w_xfer;
    logic             w_end;
    logic             w_start;
    logic             w_limit_hit;

`ifdef CLK_DIV_GEN_LIMIT_EN
    logic r_hold;
    logic r_done;

    assign w_limit_hit = w_end && (limit != 32'd0) && ((r_slow_count + 32'd1) == limit);
    // After a limit stop, run_en must be seen low before a new start is allowed.
    assign w_start     = run_en && !r_hold;
    assign done        = r_done;

    always_ff @(posedge fastclk or negedge reset_l) begin
        if (!reset_l) begin
            r_hold <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_limit_hit;
            if (w_limit_hit) begin
                r_hold <= 1'b1;
            end else if (r_state == IDLE && !run_en) begin
                r_hold <= 1'b0;
            end
        end
    end
`else
    assign w_limit_hit = 1'b0;
    assign w_start     = run_en;
`endif

    assign w_xfer        = cfg_valid && !r_pend_q;
    assign w_cfg_clamped = (cfg_div < DIV_W'(2)) ? DIV_W'(2) : cfg_div;
    assign w_end         = (r_state != IDLE) && (r_cnt == (r_div - DIV_W'(1)));

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_start) w_state_next = RUN;
            RUN:     if (!run_en) w_state_next = DRAIN;
            DRAIN: begin
                if (run_en) begin
                    w_state_next = RUN;
                end else if (w_end) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
        if (w_limit_hit) begin
            w_state_next = IDLE;
        end
    end

    // Ratio changes only land at a period boundary, so no period mixes two ratios.
    always_comb begin
        w_div_next = r_div;
        if (r_state == IDLE) begin
            if (w_xfer) w_div_next = w_cfg_clamped;
        end else if (w_end) begin
            if (r_pend_q) begin
                w_div_next = r_pend_div;
            end else if (w_xfer) begin
                w_div_next = w_cfg_clamped;
            end
        end
    end

    always_comb begin
        w_cnt_next = r_cnt + DIV_W'(1);
        if (w_state_next == IDLE || r_state == IDLE || w_end) begin
            w_cnt_next = '0;
        end
    end

    always_ff @(posedge fastclk or negedge reset_l) begin
        if (!reset_l) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_div        <= RST_DIV;
            r_pend_div   <= '0;
            r_pend_q     <= 1'b0;
            r_clk_out    <= 1'b0;
            r_tick       <= 1'b0;
            r_slow_count <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_div   <= w_div_next;
            if (w_end) begin
                r_pend_q     <= 1'b0;
                r_slow_count <= r_slow_count + 32'd1;
            end else if (r_state != IDLE && w_xfer) begin
                r_pend_q   <= 1'b1;
                r_pend_div <= w_cfg_clamped;
            end
            // Outputs are registered from the next-cycle count so they line up with r_cnt.
            r_clk_out <= (w_state_next != IDLE) && (w_cnt_next < (w_div_next >> 1));
            r_tick    <= (w_state_next != IDLE) && (w_cnt_next == (w_div_next - DIV_W'(1)));
        end
    end

    assign cfg_ready  = !r_pend_q;
    assign clk_out    = r_clk_out;
    assign tick       = r_tick;
    assign slow_count = r_slow_count;
    assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_clk_div_gen.sv
// Vector-table bench for clk_div_gen: each vector drives one cycle of inputs and its expected
// outputs go through a scoreboard queue; reset and limit behaviour use short hand sequences.
module tb_clk_div_gen;

    logic        fastclk;
    logic        reset_l;
    logic        run_en;
    logic        cfg_valid;
    logic [7:0]  cfg_div;
    logic        cfg_ready;
    logic        clk_out;
    logic        tick;
    logic [31:0] slow_count;
    logic        busy;
    logic [31:0] limit;
    logic        done_w;

    typedef struct {
        logic       run;
        logic       vld;
        logic [7:0] div;
        logic       e_clk;
        logic       e_tick;
        logic       e_busy;
        logic       e_rdy;
        logic       e_done;
    } vec_t;

    typedef struct {
        logic        clk_o;
        logic        tick_o;
        logic        busy_o;
        logic        rdy_o;
        logic        done_o;
        logic [31:0] slow;
        int          idx;
    } exp_t;

    vec_t        ph1[$];
    vec_t        ph2[$];
    vec_t        ph3[$];
    exp_t        sb[$];
    int          n_checks;
    int          n_fail;
    int          cur_idx;
    logic [31:0] exp_slow;

    clk_div_gen #(
        .DIV_W      (8),
        .DEFAULT_DIV(4)
    ) dut (
        .fastclk   (fastclk),
        .reset_l   (reset_l),
        .run_en    (run_en),
        .cfg_valid (cfg_valid),
        .cfg_div   (cfg_div),
        .cfg_ready (cfg_ready),
        .clk_out   (clk_out),
        .tick      (tick),
        .slow_count(slow_count),
        .busy      (busy)
`ifdef CLK_DIV_GEN_LIMIT_EN
        ,
        .limit     (limit),
        .done      (done_w)
`endif
    );

`ifndef CLK_DIV_GEN_LIMIT_EN
    assign done_w = 1'b0;
`endif

    initial begin
        fastclk = 1'b0;
        forever #5 fastclk = ~fastclk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s (vec %0d): got %0h, expected %0h", nm, cur_idx, act, exp_v);
        end
    endtask

    task automatic add(input int ph, input logic r, input logic v, input logic [7:0] d,
                       input logic c, input logic t, input logic b, input logic rd,
                       input logic dn);
        vec_t x;
        x.run = r; x.vld = v; x.div = d;
        x.e_clk = c; x.e_tick = t; x.e_busy = b; x.e_rdy = rd; x.e_done = dn;
        if (ph == 1) ph1.push_back(x);
        else if (ph == 2) ph2.push_back(x);
        else ph3.push_back(x);
    endtask

    task automatic run_vecs(input vec_t q[$]);
        foreach (q[i]) begin
            exp_t e;
            exp_t g;
            run_en    = q[i].run;
            cfg_valid = q[i].vld;
            cfg_div   = q[i].div;
            e.clk_o  = q[i].e_clk;
            e.tick_o = q[i].e_tick;
            e.busy_o = q[i].e_busy;
            e.rdy_o  = q[i].e_rdy;
            e.done_o = q[i].e_done;
            e.slow   = exp_slow;
            e.idx    = cur_idx;
            sb.push_back(e);
            @(posedge fastclk);
            #1;
            g = sb.pop_front();
            chk("clk_out", {31'd0, clk_out}, {31'd0, g.clk_o});
            chk("tick", {31'd0, tick}, {31'd0, g.tick_o});
            chk("busy", {31'd0, busy}, {31'd0, g.busy_o});
            chk("cfg_ready", {31'd0, cfg_ready}, {31'd0, g.rdy_o});
            chk("slow_count", slow_count, g.slow);
`ifdef CLK_DIV_GEN_LIMIT_EN
            chk("done", {31'd0, done_w}, {31'd0, g.done_o});
`endif
            // A tick cycle completes a slow period, counted from the next cycle on.
            if (q[i].e_tick) exp_slow = exp_slow + 32'd1;
            cur_idx++;
        end
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_clk_out"}, {31'd0, clk_out}, 32'd0);
        chk({tag, "_tick"}, {31'd0, tick}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_cfg_ready"}, {31'd0, cfg_ready}, 32'd1);
        chk({tag, "_slow_count"}, slow_count, 32'd0);
    endtask

    task automatic do_reset();
        reset_l   = 1'b0;
        run_en    = 1'b0;
        cfg_valid = 1'b0;
        cfg_div   = 8'd0;
        repeat (2) @(posedge fastclk);
        #1;
        check_reset_state("rst");
        exp_slow = 32'd0;
        reset_l  = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cur_idx  = 0;
        exp_slow = 32'd0;
        limit    = 32'd0;

        // Phase 1: default div 4 running, drop run_en at cnt=1, then idle load of 5.
        for (int k = 0; k < 22; k++) add(1, 1, 0, 0, (k % 4) < 2, (k % 4) == 3, 1, 1, 0);
        add(1, 0, 0, 0, 0, 0, 1, 1, 0);
        add(1, 0, 0, 0, 0, 1, 1, 1, 0);
        add(1, 0, 0, 0, 0, 0, 0, 1, 0);
        add(1, 0, 0, 0, 0, 0, 0, 1, 0);
        add(1, 0, 1, 5, 0, 0, 0, 1, 0);
        for (int k = 0; k < 5; k++) add(1, 1, 0, 0, k < 2, k == 4, 1, 1, 0);
        // Offer on a tick loads directly; offer at cnt=1 waits in pending for the tick.
        add(1, 1, 1, 4, 1, 0, 1, 1, 0);
        add(1, 1, 0, 0, 1, 0, 1, 1, 0);
        add(1, 1, 1, 8, 0, 0, 1, 0, 0);
        add(1, 1, 1, 6, 0, 1, 1, 0, 0);
        add(1, 1, 1, 6, 1, 0, 1, 1, 0);
        add(1, 1, 1, 6, 1, 0, 1, 0, 0);
        for (int k = 2; k < 8; k++) add(1, 1, 0, 0, k < 4, k == 7, 1, 0, 0);
        for (int k = 0; k < 6; k++) add(1, 1, 0, 0, k < 3, k == 5, 1, 1, 0);
        add(1, 1, 1, 0, 1, 0, 1, 1, 0);
        for (int k = 1; k < 5; k++) add(1, 1, 0, 0, (k % 2) == 0, (k % 2) == 1, 1, 1, 0);

        // Phase 2: reset restores div 4; DRAIN returns to RUN without a gap.
        add(2, 0, 0, 0, 0, 0, 0, 1, 0);
        add(2, 1, 0, 0, 1, 0, 1, 1, 0);
        add(2, 1, 0, 0, 1, 0, 1, 1, 0);
        add(2, 0, 0, 0, 0, 0, 1, 1, 0);
        add(2, 1, 0, 0, 0, 1, 1, 1, 0);
        add(2, 1, 0, 0, 1, 0, 1, 1, 0);
        add(2, 1, 0, 0, 1, 0, 1, 1, 0);

        // Phase 3: limit=3 stops after the third tick, done pulses once, restart needs a toggle.
        for (int k = 0; k < 12; k++) add(3, 1, 0, 0, (k % 4) < 2, (k % 4) == 3, 1, 1, 0);
        add(3, 1, 0, 0, 0, 0, 0, 1, 1);
        add(3, 1, 0, 0, 0, 0, 0, 1, 0);
        add(3, 1, 0, 0, 0, 0, 0, 1, 0);
        add(3, 0, 0, 0, 0, 0, 0, 1, 0);
        add(3, 1, 0, 0, 1, 0, 1, 1, 0);
        add(3, 1, 0, 0, 1, 0, 1, 1, 0);

        do_reset();
        run_vecs(ph1);

        // Mid-period reset while clk_out is high must clear everything without a clock edge.
        #2;
        reset_l = 1'b0;
        #1;
        check_reset_state("async");
        exp_slow = 32'd0;
        repeat (2) @(posedge fastclk);
        #1;
        run_en  = 1'b0;
        reset_l = 1'b1;
        run_vecs(ph2);

`ifdef CLK_DIV_GEN_LIMIT_EN
        do_reset();
        limit = 32'd3;
        run_vecs(ph3);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
